// File: rtl/nibble_rx_pkg.sv
// Shared types and helpers for the 4-state-safe nibble receiver.
package nibble_rx_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    BAD_EN
  } sample_class_e;

  // True when any bit is X or Z; reduction XOR propagates unknowns.
  function automatic logic has_xz(nibble_t n);
    return (^n === 1'bx);
  endfunction

  function automatic sample_class_e classify_en(logic en);
    if (en === 1'b0) return IDLE;
    if (en === 1'b1) return SAMPLE;
    return BAD_EN;
  endfunction

endpackage

// File: rtl/nibble_rx_checker_fifo.sv
// First-word-fall-through nibble FIFO; head entry is visible on rd_data whenever not empty.
module nibble_fifo
  import nibble_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  nibble_t wr_data,
  output nibble_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  nibble_t            mem_q [DEPTH];
  nibble_t            mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    // Flags are registered from the next occupancy so they move with it.
    full_d  = (occ_d == OCC_W'(DEPTH));
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/nibble_rx_checker.sv
// Samples 4-state nibbles, rejects X/Z, buffers clean ones and counts rejects and overflows.
module nibble_rx_checker
  import nibble_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       my_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output logic             full,
  output logic             empty,
  output logic             xz_err,
  output logic             ovf_err,
  output logic [CNT_W-1:0] xz_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  sample_class_e    cls;
  logic             cand, reject, pop, push, drop;
  logic             xz_err_q, xz_err_d;
  logic             ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0] xz_cnt_q, xz_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    cls       = classify_en(en);
    cand      = 1'b0;
    reject    = 1'b0;
    case (cls)
      SAMPLE: begin
        cand   = !has_xz(my_data);
        reject = has_xz(my_data);
      end
      BAD_EN:  reject = 1'b1;
      default: ;
    endcase
    pop  = out_valid && out_ready;
    // A full FIFO can still take a nibble when the head leaves on the same edge.
    push = cand && (!full || pop);
    drop = cand && full && !pop;

    xz_err_d  = reject;
    ovf_err_d = drop;
    xz_cnt_d  = xz_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (reject && (xz_cnt_q != {CNT_W{1'b1}}))  xz_cnt_d  = xz_cnt_q + CNT_W'(1);
    if (drop && (ovf_cnt_q != {CNT_W{1'b1}}))   ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xz_err_q  <= 1'b0;
      ovf_err_q <= 1'b0;
      xz_cnt_q  <= '0;
      ovf_cnt_q <= '0;
    end else begin
      xz_err_q  <= xz_err_d;
      ovf_err_q <= ovf_err_d;
      xz_cnt_q  <= xz_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (my_data),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign xz_err    = xz_err_q;
  assign ovf_err   = ovf_err_q;
  assign xz_cnt    = xz_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_nibble_rx_checker.sv
// Scoreboard bench for nibble_rx_checker with narrow counters so saturation is reachable.
module tb_nibble_rx_checker;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [3:0]       my_data;
  logic             out_ready;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             full, empty, xz_err, ovf_err;
  logic [CNT_W-1:0] xz_cnt, ovf_cnt;

  always #5 clk = ~clk;

  nibble_rx_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .my_data(my_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .full(full), .empty(empty),
    .xz_err(xz_err), .ovf_err(ovf_err), .xz_cnt(xz_cnt), .ovf_cnt(ovf_cnt)
  );

  int         checks = 0;
  int         failures = 0;
  logic [3:0] sb[$];
  int         m_xz, m_ovf;
  logic       m_xz_p, m_ovf_p;
  logic [3:0] last_pop;
  logic       pop_seen;
  logic [3:0] obs;

  // Drive one cycle of stimulus and advance the reference model on the edge.
  task automatic step(input logic e, input logic [3:0] d, input logic r);
    logic pop, cand, rej, push;
    en = e; my_data = d; out_ready = r;
    @(posedge clk);
    pop_seen = 1'b0;
    if (rst === 1'b1) begin
      sb.delete();
      m_xz = 0; m_ovf = 0; m_xz_p = 1'b0; m_ovf_p = 1'b0;
    end else begin
      pop  = (sb.size() > 0) && (r === 1'b1);
      cand = (e === 1'b1) && !(^d === 1'bx);
      rej  = (e !== 1'b0) && !cand;
      push = cand && ((sb.size() < DEPTH) || pop);
      m_xz_p  = rej;
      m_ovf_p = cand && !push;
      if (pop) begin
        last_pop = sb.pop_front();
        pop_seen = 1'b1;
      end
      if (push) sb.push_back(d);
      if (m_xz_p && m_xz < SAT) m_xz++;
      if (m_ovf_p && m_ovf < SAT) m_ovf++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'bx, 4'bxxxx, 1'b0);
    step(1'bx, 4'bxxxx, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL reset_flags got full=%b empty=%b exp full=0 empty=1", full, empty); end
    checks++; if (xz_err !== 1'b0 || ovf_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got xz=%b ovf=%b exp 0 0", xz_err, ovf_err); end
    checks++; if (xz_cnt !== '0 || ovf_cnt !== '0) begin failures++; $display("FAIL reset_counts got xz=%0d ovf=%0d exp 0 0", xz_cnt, ovf_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_clean_stream();
    step(1'b1, 4'hB, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'hB) begin failures++; $display("FAIL clean_first got v=%b d=%h exp v=1 d=b", out_valid, out_data); end
    obs = out_data;
    step(1'b1, 4'h3, 1'b1);
    checks++; if (!pop_seen || obs !== last_pop) begin failures++; $display("FAIL clean_pop0 got=%h exp=%h", obs, last_pop); end
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin failures++; $display("FAIL clean_second got v=%b d=%h exp v=1 d=3", out_valid, out_data); end
    obs = out_data;
    step(1'b0, 4'h0, 1'b1);
    checks++; if (!pop_seen || obs !== last_pop) begin failures++; $display("FAIL clean_pop1 got=%h exp=%h", obs, last_pop); end
    checks++; if (empty !== 1'b1 || xz_cnt !== '0) begin failures++; $display("FAIL clean_end got empty=%b xz_cnt=%0d exp 1 0", empty, xz_cnt); end
  endtask

  task automatic test_xz_reject();
    step(1'b1, 4'b1x01, 1'b1);
    checks++; if (xz_err !== m_xz_p || xz_cnt !== CNT_W'(m_xz)) begin failures++; $display("FAIL xz_data got err=%b cnt=%0d exp err=%b cnt=%0d", xz_err, xz_cnt, m_xz_p, m_xz); end
    step(1'bz, 4'h5, 1'b1);
    checks++; if (xz_err !== m_xz_p || xz_cnt !== CNT_W'(m_xz)) begin failures++; $display("FAIL xz_en got err=%b cnt=%0d exp err=%b cnt=%0d", xz_err, xz_cnt, m_xz_p, m_xz); end
    checks++; if (empty !== (sb.size() == 0)) begin failures++; $display("FAIL xz_empty got=%b exp=%b", empty, sb.size() == 0); end
    step(1'b0, 4'h0, 1'b1);
    checks++; if (xz_err !== 1'b0) begin failures++; $display("FAIL xz_pulse_width got=%b exp=0", xz_err); end
    while (sb.size() > 0) step(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_overflow();
    logic [3:0] exp_seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    step(1'b1, 4'h5, 1'b0);
    checks++; if (ovf_err !== 1'b1 || ovf_cnt !== CNT_W'(1)) begin failures++; $display("FAIL ovf_drop got err=%b cnt=%0d exp err=1 cnt=1", ovf_err, ovf_cnt); end
    step(1'b0, 4'h0, 1'b0);
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_pulse_width got=%b exp=0", ovf_err); end
    for (int i = 0; i < 4; i++) begin
      obs = out_data;
      step(1'b0, 4'h0, 1'b1);
      checks++; if (!pop_seen || obs !== last_pop || obs !== exp_seq[i]) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, obs, exp_seq[i]); end
    end
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got empty=%b v=%b exp 1 0", empty, out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_seq [4] = '{4'hB, 4'hC, 4'hD, 4'h9};
    for (int i = 0; i < 4; i++) step(1'b1, 4'(4'hA + i), 1'b0);
    obs = out_data;
    step(1'b1, 4'h9, 1'b1);
    checks++; if (ovf_err !== 1'b0 || full !== 1'b1 || sb.size() != 4) begin failures++; $display("FAIL fpp_state got ovf=%b full=%b exp ovf=0 full=1", ovf_err, full); end
    checks++; if (obs !== 4'hA || obs !== last_pop) begin failures++; $display("FAIL fpp_head got=%h exp=a", obs); end
    for (int i = 0; i < 4; i++) begin
      obs = out_data;
      step(1'b0, 4'h0, 1'b1);
      checks++; if (obs !== last_pop || obs !== exp_seq[i]) begin failures++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, obs, exp_seq[i]); end
    end
  endtask

  task automatic test_saturation_and_reset();
    for (int i = 0; i < 5; i++) step(1'bx, 4'h0, 1'b0);
    checks++; if (xz_cnt !== CNT_W'(m_xz) || xz_err !== m_xz_p) begin failures++; $display("FAIL sat_xz got cnt=%0d err=%b exp cnt=%0d err=%b", xz_cnt, xz_err, m_xz, m_xz_p); end
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 6), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 1'b0);
    checks++; if (ovf_cnt !== CNT_W'(SAT) || ovf_err !== 1'b1) begin failures++; $display("FAIL sat_ovf got cnt=%0d err=%b exp cnt=%0d err=1", ovf_cnt, ovf_err, SAT); end
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'hE, 1'b1);
    checks++; if (sb.size() != 3 || full !== 1'b0) begin failures++; $display("FAIL sat_level got full=%b exp=0", full); end
    step(1'b0, 4'h0, 1'b1);
    rst = 1'b1;
    step(1'b1, 4'h7, 1'b0);
    rst = 1'b0;
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0) begin failures++; $display("FAIL mid_reset_fifo got empty=%b v=%b d=%h exp 1 0 0", empty, out_valid, out_data); end
    checks++; if (xz_cnt !== '0 || ovf_cnt !== '0 || xz_err !== 1'b0 || ovf_err !== 1'b0) begin failures++; $display("FAIL mid_reset_err got xz=%0d ovf=%0d pxz=%b povf=%b exp all 0", xz_cnt, ovf_cnt, xz_err, ovf_err); end
  endtask

  task automatic test_back_to_back();
    logic       e, r;
    logic [3:0] d;
    int         sel;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 7);
      e = (sel == 0) ? 1'bx : (sel < 3) ? 1'b0 : 1'b1;
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) d[1] = 1'bz;
      r = ($urandom_range(0, 2) != 0);
      obs = out_data;
      step(e, d, r);
      if (pop_seen) begin
        checks++; if (obs !== last_pop) begin failures++; $display("FAIL b2b_pop[%0d] got=%h exp=%h", n, obs, last_pop); end
      end
      checks++; if (out_valid !== (sb.size() > 0) || full !== (sb.size() == DEPTH) || empty !== (sb.size() == 0)) begin
        failures++; $display("FAIL b2b_flags[%0d] got v=%b f=%b e=%b exp level=%0d", n, out_valid, full, empty, sb.size());
      end
      checks++; if (ovf_err !== m_ovf_p || xz_err !== m_xz_p || ovf_cnt !== CNT_W'(m_ovf) || xz_cnt !== CNT_W'(m_xz)) begin
        failures++; $display("FAIL b2b_err[%0d] got po=%b px=%b co=%0d cx=%0d exp po=%b px=%b co=%0d cx=%0d", n, ovf_err, xz_err, ovf_cnt, xz_cnt, m_ovf_p, m_xz_p, m_ovf, m_xz);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; my_data = 4'h0; out_ready = 1'b0;
    m_xz = 0; m_ovf = 0; m_xz_p = 1'b0; m_ovf_p = 1'b0;
    last_pop = 4'h0; pop_seen = 1'b0; obs = 4'h0;
    @(negedge clk);
    test_reset();
    test_clean_stream();
    test_xz_reject();
    test_overflow();
    test_full_push_pop();
    test_saturation_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_rx_checker.md
# nibble_rx_checker

Receive-side partner for the 4-bit `logic` data/enable pair driven by our 4-state stimulus benches. It samples a nibble whenever the enable is high and buffers clean nibbles in a small first-word-fall-through FIFO. It rejects any nibble whose data or enable carries X/Z, and keeps a saturating count of rejected and overflowed nibbles. It sits between a bench-side driver and any consumer that must only ever see 2-state values.

## Interface
Parameters:
- `DEPTH`, default 4. FIFO depth in nibbles; must be a power of two, ≥2.
- `CNT_W`, default 8. Width of each error counter.

Ports:
- `clk`, input, 1. Sole clock, rising edge.
- `rst`, input, 1. Reset, synchronous and active-high.
- `en`, input, 1. Sample strobe; 4-state.
- `my_data`, input, 4. Nibble to sample; 4-state.
- `out_ready`, input, 1. Consumer accepts the head nibble.
- `out_valid`, output, 1. Head nibble is present.
- `out_data`, output, 4. Head nibble; always 2-state.
- `full`, output, 1. Occupancy equals `DEPTH`.
- `empty`, output, 1. Occupancy equals 0.
- `xz_err`, output, 1. One-cycle pulse: a sample was rejected for X/Z.
- `ovf_err`, output, 1. One-cycle pulse: a clean sample was dropped because the FIFO was full.
- `xz_cnt`, output, `CNT_W`. Saturating count of X/Z rejects.
- `ovf_cnt`, output, `CNT_W`. Saturating count of overflow drops.

## Operation
- Each rising edge, `en` is classified as exactly one of:
  - **IDLE**: `en === 1'b0`.
  - **SAMPLE**: `en === 1'b1`.
  - **BAD_EN**: `en` is X or Z.
- SAMPLE with `my_data` fully 2-state (`^my_data !== 1'bx`): the nibble is a push candidate.
- SAMPLE with any X/Z bit in `my_data`: reject the nibble, assert `xz_err`, increment `xz_cnt`. FIFO is unchanged.
- BAD_EN: treat as an X/Z reject regardless of `my_data`.
- IDLE: no action.
- Pop: occurs when `out_valid && out_ready`; the head advances.
- Push acceptance: a push candidate is written when occupancy < `DEPTH`, or when occupancy == `DEPTH` and a pop occurs in the same cycle.
- Push dropped: otherwise, assert `ovf_err` and increment `ovf_cnt`.
- Simultaneous push and pop: occupancy is unchanged; pointers both advance.
- Pop while empty: ignored, since `out_valid` is 0.
- Pointers: `$clog2(DEPTH)` bits with natural wrap. Occupancy is held in `$clog2(DEPTH)+1` bits.
- Counters: saturate at `2**CNT_W-1` and never wrap. The pulse outputs still fire once saturated.
- `out_data` is driven from storage only. Storage is cleared on reset, so `out_data` is never X.

## Timing
- Reset values, all outputs:
  - `out_valid`=0, `out_data`=4'h0, `full`=0, `empty`=1
  - `xz_err`=0, `ovf_err`=0, `xz_cnt`=0, `ovf_cnt`=0
- Reset clears storage, both pointers and occupancy.
- Reset has priority over every other event in the same edge. A reset applied mid-stream discards all buffered nibbles and all in-flight pulses.
- Push latency: a nibble sampled at edge N appears on `out_data` with `out_valid`=1 after edge N, when the FIFO was empty (FWFT, one-cycle latency).
- `xz_err` and `ovf_err` are registered. They are high for exactly the cycle following the offending edge, with no combinational path from the inputs.
- `full` and `empty` are registered and update on the same edge as occupancy.
- No handshake on the input side: an `en` high for K consecutive edges produces K samples.

## Structure
- Shared package `nibble_rx_pkg`:
  - typedef `nibble_t` (`logic [3:0]`).
  - enum `sample_class_e` {IDLE, SAMPLE, BAD_EN}.
  - function `has_xz(nibble_t)`.
- Sub-module `nibble_fifo`: parameterized FWFT FIFO with storage, pointers, occupancy, `full` and `empty`.
- Top level: classification, accept/drop decision, pulses and saturating counters.

## Test plan
- **Reset state**: hold `rst`=1 for 2 cycles with `en`=X and `my_data`=X. Outputs equal the reset values, `out_data`=0, and there are no pulses.
- **Clean stream**: with `out_ready`=1, drive `en`=1 with `my_data`=4'hB then 4'h3.
  - `out_data`=B, then 3, each one cycle after its sample.
  - `xz_cnt`=0.
- **X/Z reject**: drive `my_data`=4'b1x01 with `en`=1, then `en`=Z with `my_data`=4'h5.
  - `xz_err` pulses twice and `xz_cnt`=2.
  - FIFO stays empty.
- **Overflow**: `DEPTH`=4, `out_ready`=0, push 1, 2, 3, 4, 5.
  - `full`=1 after the 4th push.
  - `ovf_err` pulses once and `ovf_cnt`=1.
  - Draining yields exactly 1, 2, 3, 4.
- **Full with simultaneous push/pop**: when full, push 4'h9 while `out_ready`=1.
  - No `ovf_err`; occupancy stays 4.
  - 9 emerges after the existing three remaining entries.
- **Saturation and reset mid-operation**: `CNT_W`=2 with 5 X/Z rejects gives `xz_cnt`=3. Then assert `rst` with 2 entries buffered: the next cycle shows `empty`=1 and both counters at 0.
